bus_reader: RTL and testbench
=============================

Name: bus_reader

Overview:
- Read-side controller for the team's 4-bit tri-state bus. The bus is driven by an enable-gated buffer (enable high drives D onto Q; enable low releases the bus to high-Z).
- On a read request, bus_reader asserts the buffer enable, waits a settle interval, samples the bus and queues the word in a small show-ahead FIFO.
- Downstream logic drains the FIFO with a pop strobe.

Parameters:
- W, 4, bus / data width
- DEPTH, 4, FIFO entries (power of 2, ≥2)
- SETTLE, 1, cycles en is held before sampling (≥1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (0 = reset)
- req  input  1  read request, sampled in IDLE only
- bus  input  W  shared bus value (output of the tri-state buffer)
- en  output  1  enable to the bus driver; registered
- busy  output  1  1 whenever state ≠ IDLE
- rd  input  1  pop strobe
- dout  output  W  FIFO head word (show-ahead); 0 when empty
- empty  output  1  FIFO empty
- full  output  1  FIFO full
- count  output  clog2(DEPTH)+1  entries held

Behaviour:
- Reset (reset=0, asynchronous):
  - State = IDLE; en=0, busy=0.
  - FIFO pointers and count = 0; empty=1, full=0, dout=0.
  - Takes effect immediately, including mid-read: en drops without waiting for clk, and no partial capture is written.
- FSM states: IDLE, DRIVE, CAPTURE.
  - IDLE: on an edge with req=1 and full=0, go to DRIVE, set en=1, load the settle counter to SETTLE-1. With req=1 and full=1, the request is ignored and the state stays IDLE; the requester must hold or retry.
  - DRIVE: en=1. Decrement the counter each edge. On the edge where the counter is 0, go to CAPTURE.
  - CAPTURE: en=1. On the next edge, write bus into FIFO[wptr], advance wptr, go to IDLE, set en=0.
- Timing:
  - en is high for exactly SETTLE+1 cycles per read.
  - With SETTLE=1: req accepted at edge 0; en=1 after edges 0 and 1; the word is written at edge 2; en=0 after edge 2.
  - Back-to-back: req held high gives one read every SETTLE+2 cycles (no IDLE bubble beyond that one cycle).
  - The bus value is sampled only at the end of CAPTURE; values during DRIVE are don't-care.
- FIFO:
  - Show-ahead: dout = FIFO[rptr] whenever empty=0.
  - rd=1 with empty=0: advance rptr at the edge.
  - rd=1 with empty=1: ignored, no underflow.
  - Simultaneous write (CAPTURE edge) and pop: both happen, count unchanged. This also holds when count=DEPTH-1 or count=1.
  - Overflow is impossible: a read is only started when full=0, and only one read is in flight.
  - full=1 iff count==DEPTH; empty=1 iff count==0.
  - Pointers wrap modulo DEPTH.
- All outputs are registered or derived from registered state; there are no combinational paths from req to en.
- bus containing X/Z at the sample edge is stored as-is; there is no bus-validity checking in this block.

Test Plan:
- Reset: hold reset=0, then release → en=0, busy=0, empty=1, full=0, count=0, dout=0.
- Single read, SETTLE=1: bus=4'b0101, pulse req for 1 cycle → en=1 for exactly 2 cycles, then count=1, dout=4'b0101, empty=0.
- Fill and hold-off: 4 reads with bus=1,2,3,4, then req held high → full=1, count=4, en stays 0 while full. Then rd=1 for one cycle → dout=1 is popped, the next read starts (en=1), and the final order popped is 2,3,4,<new>.
- Simultaneous push and pop: count=2 (dout=4'hA), rd=1 on the CAPTURE edge of a read with bus=4'hC → count stays 2, dout=next entry, 4'hC sits at the tail.
- Underflow: empty FIFO, rd=1 for 3 cycles → count=0, empty=1, dout=0, pointers unchanged (a following read returns its value correctly).
- Reset mid-read: assert reset=0 while state=DRIVE with en=1 → en=0 immediately (before the next clk). After release, count=0, and the captured word was never written.

Source files
------------

// File: rtl/bus_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_reader_if
// Description : Signal bundle between the bus_reader block and its requester,
//               its tri-state bus and the FIFO consumer.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_reader_if #(
    parameter int W     = 4,
    parameter int DEPTH = 4
);
    logic                     req;
    logic [W-1:0]             bus;
    logic                     en;
    logic                     busy;
    logic                     rd;
    logic [W-1:0]             dout;
    logic                     empty;
    logic                     full;
    logic [$clog2(DEPTH):0]   count;

    // Requester / consumer side
    modport master (
        output req, bus, rd,
        input  en, busy, dout, empty, full, count
    );

    // bus_reader side
    modport slave (
        input  req, bus, rd,
        output en, busy, dout, empty, full, count
    );
endinterface
`default_nettype wire

// File: rtl/bus_reader.sv
`default_nettype none
// ============================================================================
// Module      : bus_reader
// Description : Read-side controller for the shared tri-state bus. A request
//               enables the bus driver, waits SETTLE cycles, samples the bus
//               and stores the word in a show-ahead FIFO drained by rd.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_reader #(
    parameter int W      = 4,
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    bus_reader_if.slave  bif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE - 1);
    localparam logic [AW:0]   DEPTH_CNT   = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state;
    logic [CW-1:0]   settle_cnt;
    logic            en_q;
    logic            busy_q;

    logic [W-1:0]    mem [DEPTH];
    logic [AW-1:0]   wptr;
    logic [AW-1:0]   rptr;
    logic [AW:0]     count_q;

    logic            full_w;
    logic            empty_w;
    logic            push;
    logic            pop;

    // Flags come straight from the registered count, so no path from req.
    assign full_w  = (count_q == DEPTH_CNT);
    assign empty_w = (count_q == '0);
    // The write happens on the edge that leaves CAPTURE; reset forces IDLE,
    // so an interrupted read never writes.
    assign push    = (state == CAPTURE);
    assign pop     = bif.rd && !empty_w;

    // Read sequencer: enable the driver, wait out the settle time, capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            settle_cnt <= '0;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bif.req && !full_w) begin
                        state      <= DRIVE;
                        settle_cnt <= SETTLE_LOAD;
                        en_q       <= 1'b1;
                        busy_q     <= 1'b1;
                    end
                end
                DRIVE: begin
                    if (settle_cnt == '0) begin
                        state <= CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt - 1'b1;
                    end
                end
                CAPTURE: begin
                    state  <= IDLE;
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    en_q   <= 1'b0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // FIFO storage; contents need no reset because dout is gated by empty.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= bif.bus;
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop keep the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr    <= '0;
            rptr    <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign bif.en    = en_q;
    assign bif.busy  = busy_q;
    assign bif.dout  = empty_w ? '0 : mem[rptr];
    assign bif.empty = empty_w;
    assign bif.full  = full_w;
    assign bif.count = count_q;
endmodule
`default_nettype wire

// File: tb/tb_bus_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_reader
// Description : Directed self-checking bench for bus_reader with a queue of
//               expected FIFO words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_reader;
    localparam int W      = 4;
    localparam int DEPTH  = 4;
    localparam int SETTLE = 1;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    logic [W-1:0] sb[$];

    bus_reader_if #(.W(W), .DEPTH(DEPTH)) bif ();

    bus_reader #(.W(W), .DEPTH(DEPTH), .SETTLE(SETTLE)) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full read with the en profile checked; the word is queued when driven.
    task automatic read_word(input logic [W-1:0] v);
        @(negedge clk);
        bif.bus = v;
        bif.req = 1'b1;
        sb.push_back(v);
        @(negedge clk);
        bif.req = 1'b0;
        check("en_cycle1", bif.en, 1);
        check("busy_cycle1", bif.busy, 1);
        @(negedge clk);
        check("en_cycle2", bif.en, 1);
        @(negedge clk);
        check("en_off", bif.en, 0);
        check("busy_off", bif.busy, 0);
    endtask

    // Pop one word and compare the head against the scoreboard.
    task automatic pop_check(input string tag);
        logic [W-1:0] exp;
        @(negedge clk);
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s observed=pop expected=scoreboard_entry", tag);
        end else begin
            exp = sb.pop_front();
            check(tag, bif.dout, exp);
        end
        bif.rd = 1'b1;
        @(negedge clk);
        bif.rd = 1'b0;
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b0;
        bif.req  = 1'b0;
        bif.rd   = 1'b0;
        bif.bus  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_en", bif.en, 0);
        check("rst_busy", bif.busy, 0);
        check("rst_empty", bif.empty, 1);
        check("rst_full", bif.full, 0);
        check("rst_count", bif.count, 0);
        check("rst_dout", bif.dout, 0);

        // Single read
        read_word(4'b0101);
        check("single_count", bif.count, 1);
        check("single_empty", bif.empty, 0);
        check("single_dout", bif.dout, 4'b0101);
        pop_check("single_pop");
        check("single_empty_after", bif.empty, 1);

        // Fill and hold-off
        read_word(4'h1);
        read_word(4'h2);
        read_word(4'h3);
        read_word(4'h4);
        check("fill_full", bif.full, 1);
        check("fill_count", bif.count, 4);
        bif.bus = 4'h5;
        bif.req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("holdoff_en", bif.en, 0);
        end
        check("holdoff_dout", bif.dout, sb.pop_front());
        bif.rd = 1'b1;
        @(negedge clk);
        bif.rd = 1'b0;
        check("holdoff_count", bif.count, 3);
        check("holdoff_full", bif.full, 0);
        @(negedge clk);
        check("resume_en", bif.en, 1);
        bif.req = 1'b0;
        sb.push_back(4'h5);
        @(negedge clk);
        @(negedge clk);
        check("resume_en_off", bif.en, 0);
        check("resume_count", bif.count, 4);
        pop_check("order_pop0");
        pop_check("order_pop1");
        pop_check("order_pop2");
        pop_check("order_pop3");
        check("order_empty", bif.empty, 1);

        // Simultaneous push and pop at count=2
        read_word(4'hA);
        read_word(4'hB);
        check("sim_pre_count", bif.count, 2);
        check("sim_pre_dout", bif.dout, 4'hA);
        @(negedge clk);
        bif.bus = 4'hC;
        bif.req = 1'b1;
        sb.push_back(4'hC);
        @(negedge clk);
        bif.req = 1'b0;
        @(negedge clk);
        check("sim_capture_dout", bif.dout, sb.pop_front());
        bif.rd = 1'b1;
        @(negedge clk);
        bif.rd = 1'b0;
        check("sim_count", bif.count, 2);
        check("sim_dout_next", bif.dout, 4'hB);
        pop_check("sim_pop_b");
        pop_check("sim_pop_tail");

        // Underflow
        bif.rd = 1'b1;
        repeat (3) @(negedge clk);
        bif.rd = 1'b0;
        check("under_count", bif.count, 0);
        check("under_empty", bif.empty, 1);
        check("under_dout", bif.dout, 0);
        read_word(4'h9);
        check("under_read_count", bif.count, 1);
        pop_check("under_read_pop");

        // Reset mid-read
        @(negedge clk);
        bif.bus = 4'hF;
        bif.req = 1'b1;
        @(negedge clk);
        bif.req = 1'b0;
        check("midrst_en_before", bif.en, 1);
        #1 reset = 1'b0;
        #1;
        check("midrst_en_async", bif.en, 0);
        check("midrst_busy_async", bif.busy, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_count", bif.count, 0);
        check("midrst_empty", bif.empty, 1);
        check("midrst_en", bif.en, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
